// File: rtl/pc_seq_pkg.sv
// Shared PC control codes and fetch-sequencer state encoding.
package pc_seq_pkg;

   localparam logic [1:0] PC_HOLD = 2'b00;
   localparam logic [1:0] PC_LOAD = 2'b01;
   localparam logic [1:0] PC_INC  = 2'b10;
   localparam logic [1:0] PC_ADD  = 2'b11;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] ISSUE = 2'd2;

endpackage

// File: rtl/seq_timeout_ctr.sv
// Fetch watchdog: counts FETCH cycles without an ack, flags the TIMEOUT-th one.
module seq_timeout_ctr #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic clr,
   input  logic start,
   input  logic tick,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge clr) begin
      if (clr)
         count <= '0;
      else if (start)
         count <= '0;
      else if (tick)
         count <= count + CW'(1);
   end

   // Fires during the last waiting cycle so the FSM leaves FETCH at that edge.
   assign expired = tick && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/pc_fetch_seq.sv
// Fetch sequencer: drives PC control, fetches over req/ack, issues over valid/ready.
// Optional fetch watchdog enabled by PC_FETCH_TIMEOUT_EN.
module pc_fetch_seq
   import pc_seq_pkg::*;
#(
   parameter int D_WIDTH = 4,
   parameter int I_WIDTH = 16,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               run,
   output logic               mem_req,
   input  logic               mem_ack,
   input  logic [I_WIDTH-1:0] mem_data,
   output logic [I_WIDTH-1:0] ir_out,
   output logic               ir_valid,
   input  logic               ir_ready,
   input  logic               br_req,
   input  logic               br_rel,
   input  logic [D_WIDTH-1:0] br_target,
   output logic               br_ack,
   output logic [1:0]         pc_ctrl,
   output logic [D_WIDTH-1:0] pc_in,
   output logic               busy,
   output logic               fault
);

   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("TIMEOUT must be at least 2");
   end

   logic [1:0] state, state_nxt;
   logic       redirect, load_ir, drop_ir, expired;

   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      br_ack    = 1'b0;
      pc_ctrl   = PC_HOLD;
      pc_in     = '0;
      load_ir   = 1'b0;
      drop_ir   = 1'b0;
      redirect  = 1'b0;
      case (state)
         IDLE: begin
            if (!fault) begin
               if (br_req)
                  redirect = 1'b1;
               else if (run)
                  state_nxt = FETCH;
            end
         end
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               pc_ctrl   = PC_INC;
               load_ir   = 1'b1;
               state_nxt = ISSUE;
            end else if (expired) begin
               state_nxt = IDLE;
            end
         end
         ISSUE: begin
            if (br_req) begin
               redirect = 1'b1;
            end else if (ir_ready) begin
               drop_ir   = 1'b1;
               state_nxt = run ? FETCH : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // A redirect flushes any held instruction; relative offsets land on the incremented PC.
      if (redirect) begin
         br_ack    = 1'b1;
         pc_in     = br_target;
         pc_ctrl   = br_rel ? PC_ADD : PC_LOAD;
         drop_ir   = 1'b1;
         state_nxt = run ? FETCH : IDLE;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state    <= IDLE;
         ir_out   <= '0;
         ir_valid <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load_ir) begin
            ir_out   <= mem_data;
            ir_valid <= 1'b1;
         end else if (drop_ir) begin
            ir_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

`ifdef PC_FETCH_TIMEOUT_EN
   logic wd_start, wd_tick;

   assign wd_start = (state != FETCH) && (state_nxt == FETCH);
   assign wd_tick  = (state == FETCH) && !mem_ack;

   seq_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_wd (
      .clk     (clk),
      .clr     (clr),
      .start   (wd_start),
      .tick    (wd_tick),
      .expired (expired)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr)
         fault <= 1'b0;
      else if (expired)
         fault <= 1'b1;
   end
`else
   assign expired = 1'b0;
   assign fault   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq with a behavioural PC register on pc_ctrl/pc_in.
module tb_pc_fetch_seq;

   logic        clk = 1'b0;
   logic        clr;
   logic        run;
   logic        mem_req;
   logic        mem_ack;
   logic [15:0] mem_data;
   logic [15:0] ir_out;
   logic        ir_valid;
   logic        ir_ready;
   logic        br_req;
   logic        br_rel;
   logic [3:0]  br_target;
   logic        br_ack;
   logic [1:0]  pc_ctrl;
   logic [3:0]  pc_in;
   logic        busy;
   logic        fault;
   logic [3:0]  pc;

   int n_assert = 0;
   int n_fail   = 0;

   pc_fetch_seq #(.D_WIDTH(4), .I_WIDTH(16), .TIMEOUT(8)) dut (
      .clk       (clk),
      .clr       (clr),
      .run       (run),
      .mem_req   (mem_req),
      .mem_ack   (mem_ack),
      .mem_data  (mem_data),
      .ir_out    (ir_out),
      .ir_valid  (ir_valid),
      .ir_ready  (ir_ready),
      .br_req    (br_req),
      .br_rel    (br_rel),
      .br_target (br_target),
      .br_ack    (br_ack),
      .pc_ctrl   (pc_ctrl),
      .pc_in     (pc_in),
      .busy      (busy),
      .fault     (fault)
   );

   always #5 clk = ~clk;

   // Program counter as the sequencer expects it to behave.
   always_ff @(posedge clk or posedge clr) begin
      if (clr)
         pc <= 4'h0;
      else
         case (pc_ctrl)
            2'b01:   pc <= pc_in;
            2'b10:   pc <= pc + 4'h1;
            2'b11:   pc <= pc + pc_in;
            default: pc <= pc;
         endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered in FETCH; returns one cycle into ISSUE with the word latched.
   task automatic fetch_issue(input logic [15:0] data, input logic [3:0] pc_exp);
      chk("fetch mem_req", {31'd0, mem_req}, 32'd1);
      mem_ack  = 1'b1;
      mem_data = data;
      #1;
      chk("fetch pc_ctrl inc", {30'd0, pc_ctrl}, 32'd2);
      tick();
      mem_ack  = 1'b0;
      mem_data = 16'h0000;
      #1;
      chk("issue ir_valid", {31'd0, ir_valid}, 32'd1);
      chk("issue ir_out", {16'd0, ir_out}, {16'd0, data});
      chk("issue mem_req", {31'd0, mem_req}, 32'd0);
      chk("issue pc", {28'd0, pc}, {28'd0, pc_exp});
   endtask

   initial begin
      logic [15:0] words [3];
      words[0] = 16'hA5A5;
      words[1] = 16'h1234;
      words[2] = 16'h0F0F;

      clr = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_data = 16'h0000; ir_ready = 1'b0;
      br_req = 1'b0; br_rel = 1'b0; br_target = 4'h0;
      tick();
      chk("reset mem_req", {31'd0, mem_req}, 32'd0);
      chk("reset ir_valid", {31'd0, ir_valid}, 32'd0);
      chk("reset ir_out", {16'd0, ir_out}, 32'd0);
      chk("reset pc_ctrl", {30'd0, pc_ctrl}, 32'd0);
      chk("reset pc_in", {28'd0, pc_in}, 32'd0);
      chk("reset br_ack", {31'd0, br_ack}, 32'd0);
      chk("reset fault", {31'd0, fault}, 32'd0);
      chk("reset busy", {31'd0, busy}, 32'd0);

      // Straight-line fetch, zero-wait memory.
      clr = 1'b0; run = 1'b1; ir_ready = 1'b1;
      #1;
      chk("idle busy", {31'd0, busy}, 32'd0);
      tick();
      for (int i = 0; i < 3; i++) begin
         fetch_issue(words[i], 4'(i + 1));
         chk("issue transfer pc_ctrl hold", {30'd0, pc_ctrl}, 32'd0);
         if (i == 2) run = 1'b0;
         tick();
         chk("transfer ir_valid", {31'd0, ir_valid}, 32'd0);
         chk("transfer busy", {31'd0, busy}, (i == 2) ? 32'd0 : 32'd1);
      end
      chk("straight-line pc", {28'd0, pc}, 32'h3);

      // Backpressure for four cycles, transfer on the fifth.
      run = 1'b1; ir_ready = 1'b0;
      tick();
      fetch_issue(16'hBEEF, 4'h4);
      for (int k = 0; k < 4; k++) begin
         chk("bp ir_valid", {31'd0, ir_valid}, 32'd1);
         chk("bp ir_out", {16'd0, ir_out}, 32'hBEEF);
         chk("bp mem_req", {31'd0, mem_req}, 32'd0);
         chk("bp pc_ctrl", {30'd0, pc_ctrl}, 32'd0);
         tick();
      end
      ir_ready = 1'b1;
      tick();
      chk("bp transfer ir_valid", {31'd0, ir_valid}, 32'd0);
      chk("bp next fetch mem_req", {31'd0, mem_req}, 32'd1);

      // Absolute branch in ISSUE beats ir_ready.
      fetch_issue(16'h1111, 4'h5);
      br_req = 1'b1; br_rel = 1'b0; br_target = 4'hC;
      #1;
      chk("abs br_ack", {31'd0, br_ack}, 32'd1);
      chk("abs pc_ctrl", {30'd0, pc_ctrl}, 32'd1);
      chk("abs pc_in", {28'd0, pc_in}, 32'hC);
      tick();
      br_req = 1'b0;
      #1;
      chk("abs br_ack drop", {31'd0, br_ack}, 32'd0);
      chk("abs flushed ir_valid", {31'd0, ir_valid}, 32'd0);
      chk("abs fetch mem_req", {31'd0, mem_req}, 32'd1);
      chk("abs pc", {28'd0, pc}, 32'hC);

      // Walk PC to E, then a relative branch deferred through a 3-cycle fetch wait.
      fetch_issue(16'h2222, 4'hD);
      tick();
      fetch_issue(16'h3333, 4'hE);
      tick();
      br_req = 1'b1; br_rel = 1'b1; br_target = 4'h3; ir_ready = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("rel wait br_ack", {31'd0, br_ack}, 32'd0);
         chk("rel wait mem_req", {31'd0, mem_req}, 32'd1);
         chk("rel wait pc_ctrl", {30'd0, pc_ctrl}, 32'd0);
         tick();
      end
      fetch_issue(16'h4444, 4'hF);
      chk("rel br_ack", {31'd0, br_ack}, 32'd1);
      chk("rel pc_ctrl", {30'd0, pc_ctrl}, 32'd3);
      chk("rel pc_in", {28'd0, pc_in}, 32'h3);
      tick();
      br_req = 1'b0;
      #1;
      chk("rel wrapped pc", {28'd0, pc}, 32'h2);
      chk("rel fetch mem_req", {31'd0, mem_req}, 32'd1);

      // Reset while a fetch is outstanding.
      clr = 1'b1;
      #1;
      chk("midreset mem_req", {31'd0, mem_req}, 32'd0);
      chk("midreset ir_valid", {31'd0, ir_valid}, 32'd0);
      chk("midreset ir_out", {16'd0, ir_out}, 32'd0);
      chk("midreset pc_ctrl", {30'd0, pc_ctrl}, 32'd0);
      chk("midreset fault", {31'd0, fault}, 32'd0);
      chk("midreset busy", {31'd0, busy}, 32'd0);
      tick();

`ifdef PC_FETCH_TIMEOUT_EN
      clr = 1'b0; run = 1'b1;
      tick();
      for (int k = 0; k < 8; k++) begin
         chk("wd waiting fault", {31'd0, fault}, 32'd0);
         chk("wd waiting mem_req", {31'd0, mem_req}, 32'd1);
         tick();
      end
      chk("wd fault", {31'd0, fault}, 32'd1);
      chk("wd mem_req", {31'd0, mem_req}, 32'd0);
      chk("wd busy", {31'd0, busy}, 32'd0);
      br_req = 1'b1; br_rel = 1'b0; br_target = 4'h7;
      #1;
      chk("wd br_ack blocked", {31'd0, br_ack}, 32'd0);
      tick();
      tick();
      chk("wd stays idle", {31'd0, busy}, 32'd0);
      chk("wd no mem_req", {31'd0, mem_req}, 32'd0);
      br_req = 1'b0;
      clr = 1'b1;
      #1;
      chk("wd fault cleared", {31'd0, fault}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
